gray_window_3x3: RTL

- Sits between rgb_to_grayscale and the Sobel kernel.
- Consumes the grayscale pixel stream (grayscale byte plus a done/valid strobe) in raster order, bottom-up BMP order, with no reordering.
- Buffers two image lines and emits one complete 3x3 neighbourhood per accepted pixel once the neighbourhood lies inside the frame.
- Sobel consumes window_o/done_o directly, with no further alignment.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/line_buffer.sv | 25 ++
 rtl/gray_window_3x3.sv | 119 +++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the grayscale window and Sobel stages.
// Slice offsets index window_o/Sobel inputs, p00 in the top byte.
package sobel_pkg;

    localparam int PIXEL_W = 8;
    localparam int WIN_W   = 9 * PIXEL_W;
    localparam int TAPS    = 3;

    localparam int P00 = 8 * PIXEL_W;
    localparam int P01 = 7 * PIXEL_W;
    localparam int P02 = 6 * PIXEL_W;
    localparam int P10 = 5 * PIXEL_W;
    localparam int P11 = 4 * PIXEL_W;
    localparam int P12 = 3 * PIXEL_W;
    localparam int P20 = 2 * PIXEL_W;
    localparam int P21 = 1 * PIXEL_W;
    localparam int P22 = 0;

    function automatic int tap_offset(input int row, input int col, input int pw);
        return (8 - (TAPS * row + col)) * pw;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line RAM: synchronous write, asynchronous read of the
// pre-write contents so old data is visible in the accepting cycle.
module line_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/gray_window_3x3.sv
// Two-line buffered 3x3 neighbourhood generator for the Sobel stage.
// One registered window per accepted pixel once inside the frame.
module gray_window_3x3
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIXEL_W    = sobel_pkg::PIXEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIXEL_W-1:0]   grayscale_i,
    input  logic                 done_i,
    output logic [9*PIXEL_W-1:0] window_o,
    output logic                 done_o,
    output logic                 eof_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          eof_q, eof_d;
    logic [9*PIXEL_W-1:0] win_q, win_d;

    // sr[row][tap]: row 0 is r-2, tap 0 is the oldest column
    logic [TAPS-1:0][TAPS-1:0][PIXEL_W-1:0] sr_q, sr_d;

    logic [PIXEL_W-1:0] lb1_rd, lb2_rd;
    logic last_col, last_row, in_frame;

    line_buffer #(
        .DEPTH(IMG_WIDTH),
        .WIDTH(PIXEL_W),
        .AW   (CW)
    ) u_lb1 (
        .clk    (clk),
        .we_i   (done_i),
        .addr_i (col_q),
        .wdata_i(grayscale_i),
        .rdata_o(lb1_rd)
    );

    line_buffer #(
        .DEPTH(IMG_WIDTH),
        .WIDTH(PIXEL_W),
        .AW   (CW)
    ) u_lb2 (
        .clk    (clk),
        .we_i   (done_i),
        .addr_i (col_q),
        .wdata_i(lb1_rd),
        .rdata_o(lb2_rd)
    );

    assign last_col = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
    assign in_frame = (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        sr_d   = sr_q;
        col_d  = col_q;
        row_d  = row_q;
        done_d = 1'b0;
        eof_d  = 1'b0;
        win_d  = win_q;
        if (done_i) begin
            for (int k = 0; k < TAPS; k++) begin
                sr_d[k][0] = sr_q[k][1];
                sr_d[k][1] = sr_q[k][2];
            end
            sr_d[0][2] = lb2_rd;
            sr_d[1][2] = lb1_rd;
            sr_d[2][2] = grayscale_i;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (in_frame) begin
                done_d = 1'b1;
                eof_d  = last_col && last_row;
                for (int k = 0; k < TAPS; k++) begin
                    for (int t = 0; t < TAPS; t++) begin
                        win_d[tap_offset(k, t, PIXEL_W) +: PIXEL_W] = sr_d[k][t];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
            eof_q  <= 1'b0;
            win_q  <= '0;
            sr_q   <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            done_q <= done_d;
            eof_q  <= eof_d;
            win_q  <= win_d;
            sr_q   <= sr_d;
        end
    end

    assign window_o = win_q;
    assign done_o   = done_q;
    assign eof_o    = eof_q;

endmodule
